// File: rtl/io_oa_precess.sv
// rtl/io_oa_precess.sv - G-15 input-side OA character precession register
//
// Purpose:
//   Takes one character at a time from the input device and holds it in
//   the four-bit OA register (OA1..OA4). At the next word marker (T0) it
//   precesses the character through OA, OA4 first, under the OG gate. A
//   digit takes four OG cycles on OA4. A sign/terminator takes one OG
//   cycle, with OF3 high, and is read on OA1.
//
// Ports:
//   CLOCK      in   bit-time clock, one drum bit per cycle
//   rst        in   synchronous active-high reset
//   T0         in   word-time marker, one cycle per 29-cycle word
//   IN         in   input mode; low aborts and holds the block idle
//   CH_VALID   in   device presents a character
//   CH_SIGN    in   character is a sign/terminator rather than a digit
//   CH_DATA    in   digit value; bit 0 carries the sign bit for a sign
//   CH_READY   out  block can accept a character this cycle
//   OA1..OA4   out  OA register bits
//   OG         out  precession gate, high on each shift cycle
//   OF3        out  1-bit-precession flag, high with OG for a sign
//   DIGITS     out  digits precessed since the last sign, saturating at 7
//   DIGIT_OVF  out  sticky: a digit was accepted while DIGITS == 7

module io_oa_precess (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T0,
  input  logic       IN,
  input  logic       CH_VALID,
  input  logic       CH_SIGN,
  input  logic [3:0] CH_DATA,
  output logic       CH_READY,
  output logic       OA1,
  output logic       OA2,
  output logic       OA3,
  output logic       OA4,
  output logic       OG,
  output logic       OF3,
  output logic [2:0] DIGITS,
  output logic       DIGIT_OVF
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] oa;        // oa[3] = OA4 ... oa[0] = OA1
  logic [1:0] shift_cnt; // remaining shift edges after the current one
  logic       kind_sign; // 1 = sign/terminator, 0 = digit
  logic       og_q;
  logic       of3_q;
  logic [2:0] digits_q;
  logic       ovf_q;

  assign CH_READY  = (state == IDLE) & IN;
  assign OA4       = oa[3];
  assign OA3       = oa[2];
  assign OA2       = oa[1];
  assign OA1       = oa[0];
  assign OG        = og_q;
  assign OF3       = of3_q;
  assign DIGITS    = digits_q;
  assign DIGIT_OVF = ovf_q;

  // OG and OF3 are kept as flops that change together with the state, so
  // they are high exactly while the state is SHIFT and never glitch.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state     <= IDLE;
      oa        <= 4'b0000;
      shift_cnt <= 2'd0;
      kind_sign <= 1'b0;
      og_q      <= 1'b0;
      of3_q     <= 1'b0;
      digits_q  <= 3'd0;
      ovf_q     <= 1'b0;
    end else if (!IN) begin
      // Abort: drop any held character; digit bookkeeping survives.
      state <= IDLE;
      oa    <= 4'b0000;
      og_q  <= 1'b0;
      of3_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // IN is known high here, so CH_READY is asserted.
          if (CH_VALID) begin
            state     <= LOADED;
            kind_sign <= CH_SIGN;
            if (CH_SIGN) begin
              oa <= {3'b000, CH_DATA[0]};
            end else begin
              oa <= CH_DATA;
              if (digits_q == 3'd7) begin
                ovf_q <= 1'b1;
              end
            end
          end
        end

        LOADED: begin
          // A T0 seen in the accept cycle was sampled while still IDLE, so
          // only a later T0 can start the precession.
          if (T0) begin
            state     <= SHIFT;
            shift_cnt <= kind_sign ? 2'd0 : 2'd3;
            og_q      <= 1'b1;
            of3_q     <= kind_sign;
          end
        end

        SHIFT: begin
          oa <= {oa[2:0], 1'b0};
          if (shift_cnt == 2'd0) begin
            state <= IDLE;
            og_q  <= 1'b0;
            of3_q <= 1'b0;
            if (kind_sign) begin
              digits_q <= 3'd0;
              ovf_q    <= 1'b0;
            end else if (digits_q != 3'd7) begin
              digits_q <= digits_q + 3'd1;
            end
          end else begin
            shift_cnt <= shift_cnt - 2'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_oa_precess.sv
// tb/tb_io_oa_precess.sv - self-checking bench for io_oa_precess
module tb_io_oa_precess;

  logic       CLOCK;
  logic       rst;
  logic       T0;
  logic       IN;
  logic       CH_VALID;
  logic       CH_SIGN;
  logic [3:0] CH_DATA;
  logic       CH_READY;
  logic       OA1, OA2, OA3, OA4;
  logic       OG;
  logic       OF3;
  logic [2:0] DIGITS;
  logic       DIGIT_OVF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: digit count and overflow flag as plain integers.
  int exp_digits = 0;
  bit exp_ovf = 0;

  io_oa_precess dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .T0        (T0),
    .IN        (IN),
    .CH_VALID  (CH_VALID),
    .CH_SIGN   (CH_SIGN),
    .CH_DATA   (CH_DATA),
    .CH_READY  (CH_READY),
    .OA1       (OA1),
    .OA2       (OA2),
    .OA3       (OA3),
    .OA4       (OA4),
    .OG        (OG),
    .OF3       (OF3),
    .DIGITS    (DIGITS),
    .DIGIT_OVF (DIGIT_OVF)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Cycle n is the period after posedge n; T0 is high in cycle n iff n%29==0.
  initial begin
    T0 = 1'b0;
    forever begin
      @(posedge CLOCK);
      cyc = cyc + 1;
      #1 T0 = ((cyc % 29) == 0);
    end
  end

  task automatic next_cycle;
    @(posedge CLOCK);
    #1;
  endtask

  // Send one character and follow it through its precession window.
  // align >= 0: drive CH_VALID in a cycle c with T0 in cycle c+align.
  task automatic do_char(input bit sign, input logic [3:0] data,
                         input int align, input int delay);
    int k, t, first, last, idx;
    bit ok;
    bit exp_og, exp_bit;
    logic [3:0] exp_oa;
    repeat (delay) next_cycle;
    if (align >= 0) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        if (((cyc + align) % 29) == 0) begin
          ok = 1;
          break;
        end
        next_cycle;
      end
      if (!ok) begin
        errors++;
        $display("FAIL align_timeout cyc=%0d", cyc);
      end
    end
    checks++;
    if (CH_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept cyc=%0d got=%b exp=1", cyc, CH_READY);
    end
    CH_VALID = 1'b1;
    CH_SIGN  = sign;
    CH_DATA  = data;
    if (!sign && exp_digits == 7) exp_ovf = 1;
    next_cycle;
    CH_VALID = 1'b0;
    CH_SIGN  = 1'($urandom);
    CH_DATA  = 4'($urandom);
    k     = cyc;
    t     = ((k + 28) / 29) * 29;
    first = t + 1;
    last  = sign ? t + 1 : t + 4;
    exp_oa = sign ? {3'b000, data[0]} : data;
    for (int n = k; n <= last + 1; n++) begin
      @(negedge CLOCK);
      exp_og = (n >= first) && (n <= last);
      if (n == last + 1) begin
        if (sign) begin
          exp_digits = 0;
          exp_ovf    = 0;
        end else begin
          exp_digits = (exp_digits < 7) ? exp_digits + 1 : 7;
        end
      end
      checks++;
      if (OG !== exp_og) begin
        errors++;
        $display("FAIL og cyc=%0d got=%b exp=%b", n, OG, exp_og);
      end
      checks++;
      if (OF3 !== (exp_og & sign)) begin
        errors++;
        $display("FAIL of3 cyc=%0d got=%b exp=%b", n, OF3, exp_og & sign);
      end
      checks++;
      if (CH_READY !== (n == last + 1)) begin
        errors++;
        $display("FAIL ready cyc=%0d got=%b exp=%b", n, CH_READY, n == last + 1);
      end
      if (exp_og) begin
        idx = n - first;
        if (sign) begin
          checks++;
          if (OA1 !== data[0]) begin
            errors++;
            $display("FAIL sign_bit cyc=%0d got=%b exp=%b", n, OA1, data[0]);
          end
        end else begin
          exp_bit = data[3 - idx];
          checks++;
          if (OA4 !== exp_bit) begin
            errors++;
            $display("FAIL digit_bit cyc=%0d idx=%0d got=%b exp=%b", n, idx, OA4, exp_bit);
          end
        end
      end
      if (n == k) begin
        checks++;
        if ({OA4, OA3, OA2, OA1} !== exp_oa) begin
          errors++;
          $display("FAIL oa_loaded cyc=%0d got=%b exp=%b", n, {OA4, OA3, OA2, OA1}, exp_oa);
        end
      end
      if (n == k || n == last + 1) begin
        checks++;
        if (DIGITS !== 3'(exp_digits)) begin
          errors++;
          $display("FAIL digits cyc=%0d got=%0d exp=%0d", n, DIGITS, exp_digits);
        end
        checks++;
        if (DIGIT_OVF !== exp_ovf) begin
          errors++;
          $display("FAIL digit_ovf cyc=%0d got=%b exp=%b", n, DIGIT_OVF, exp_ovf);
        end
      end
      if (n <= last) next_cycle;
    end
    next_cycle;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    IN = 1'b1;
    CH_VALID = 1'b0;
    CH_SIGN = 1'b0;
    CH_DATA = 4'h0;
    repeat (3) next_cycle;
    rst = 1'b0;
    for (int i = 0; i < 62; i++) begin
      @(negedge CLOCK);
      checks++;
      if ({OG, OF3, OA4, OA3, OA2, OA1, DIGITS, DIGIT_OVF} !== 10'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc,
                 {OG, OF3, OA4, OA3, OA2, OA1, DIGITS, DIGIT_OVF});
      end
      checks++;
      if (CH_READY !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready cyc=%0d got=%b exp=1", cyc, CH_READY);
      end
      next_cycle;
    end
    exp_digits = 0;
    exp_ovf = 0;
  endtask

  task automatic test_digit;
    do_char(1'b0, 4'hB, 5, 0);
  endtask

  task automatic test_sign;
    do_char(1'b0, 4'($urandom), -1, 2);
    do_char(1'b0, 4'($urandom), -1, 0);
    do_char(1'b1, 4'h1, -1, 3);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 8; i++) do_char(1'b0, 4'($urandom), -1, int'($urandom_range(0, 3)));
    do_char(1'b1, 4'($urandom), -1, 1);
  endtask

  task automatic test_same_cycle_t0;
    do_char(1'b0, 4'($urandom), 0, 0);
    do_char(1'b1, 4'($urandom), 0, 0);
  endtask

  task automatic test_in_abort;
    int k, t;
    bit ok;
    // Enter with a known DIGITS value.
    do_char(1'b0, 4'($urandom), -1, 0);
    CH_VALID = 1'b1;
    CH_SIGN  = 1'b0;
    CH_DATA  = 4'($urandom);
    if (exp_digits == 7) exp_ovf = 1;
    next_cycle;
    CH_VALID = 1'b0;
    k = cyc;
    t = ((k + 28) / 29) * 29;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (cyc == t + 2) begin
        ok = 1;
        break;
      end
      next_cycle;
    end
    if (!ok) begin
      errors++;
      $display("FAIL abort_timeout cyc=%0d", cyc);
    end
    @(negedge CLOCK);
    checks++;
    if (OG !== 1'b1) begin
      errors++;
      $display("FAIL abort_og_before cyc=%0d got=%b exp=1", cyc, OG);
    end
    next_cycle;
    IN = 1'b0;
    next_cycle;
    @(negedge CLOCK);
    checks++;
    if ({OG, OF3, OA4, OA3, OA2, OA1} !== 6'b0) begin
      errors++;
      $display("FAIL abort_clear cyc=%0d got=%b exp=0", cyc, {OG, OF3, OA4, OA3, OA2, OA1});
    end
    checks++;
    if (DIGITS !== 3'(exp_digits) || DIGIT_OVF !== exp_ovf) begin
      errors++;
      $display("FAIL abort_digits cyc=%0d got=%0d/%b exp=%0d/%b", cyc, DIGITS, DIGIT_OVF,
               exp_digits, exp_ovf);
    end
    for (int i = 0; i < 35; i++) begin
      next_cycle;
      @(negedge CLOCK);
      checks++;
      if (CH_READY !== 1'b0 || OG !== 1'b0) begin
        errors++;
        $display("FAIL abort_hold cyc=%0d ready=%b og=%b exp=0/0", cyc, CH_READY, OG);
      end
    end
    next_cycle;
    IN = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (CH_READY !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready_return cyc=%0d got=%b exp=1", cyc, CH_READY);
    end
    next_cycle;
  endtask

  task automatic test_rst_loaded;
    do_char(1'b0, 4'($urandom), -1, 0);
    // Accept well before a T0 so the block sits in LOADED.
    while ((cyc % 29) != 3) next_cycle;
    CH_VALID = 1'b1;
    CH_SIGN  = 1'b0;
    CH_DATA  = 4'hF;
    next_cycle;
    CH_VALID = 1'b0;
    next_cycle;
    rst = 1'b1;
    CH_VALID = 1'b1;
    next_cycle;
    rst = 1'b0;
    CH_VALID = 1'b0;
    exp_digits = 0;
    exp_ovf = 0;
    @(negedge CLOCK);
    checks++;
    if ({OG, OF3, OA4, OA3, OA2, OA1, DIGITS, DIGIT_OVF} !== 10'b0 || CH_READY !== 1'b1) begin
      errors++;
      $display("FAIL rst_loaded cyc=%0d got=%b ready=%b exp=0 ready=1", cyc,
               {OG, OF3, OA4, OA3, OA2, OA1, DIGITS, DIGIT_OVF}, CH_READY);
    end
    for (int i = 0; i < 35; i++) begin
      next_cycle;
      @(negedge CLOCK);
      checks++;
      if (OG !== 1'b0 || CH_READY !== 1'b1) begin
        errors++;
        $display("FAIL rst_no_accept cyc=%0d og=%b ready=%b exp=0/1", cyc, OG, CH_READY);
      end
    end
    next_cycle;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      do_char(($urandom_range(0, 3) == 0), 4'($urandom), -1, int'($urandom_range(0, 12)));
    end
  endtask

  initial begin
    test_reset;
    test_digit;
    test_sign;
    test_saturate;
    test_same_cycle_t0;
    test_in_abort;
    test_rst_loaded;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
